fetch_sequencer: RTL and testbench

Instruction-fetch sequencer that owns the 8-bit program counter register and drives the control inputs of the combinational next-PC logic: jump, jump_address, branch and branch_offset. It fetches one 16-bit instruction per PC from instruction memory over a req/ack handshake and decodes the control-flow opcodes. It hands each instruction to decode over a valid/ready handshake, then loads pc_next back into the PC. An optional return-address stack adds CALL/RET support.

---
 rtl/fetch_sequencer_pkg.sv | 21 ++
 rtl/fetch_sequencer_ras_stack.sv | 61 ++++++
 rtl/fetch_sequencer.sv | 169 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer: opcodes,
// instruction field positions and the FSM state type.
package fetch_sequencer_pkg;

   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_BEQZ = 4'hD;
   localparam logic [3:0] OP_CALL = 4'hE;
   localparam logic [3:0] OP_RET  = 4'hF;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2
   } state_e;

endpackage

// File: rtl/fetch_sequencer_ras_stack.sv
// Return-address stack: circular LIFO. A push when full overwrites the
// oldest entry; a pop when empty is ignored (the caller flags the error).
module ras_stack #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d, top_idx;
   logic [PTR_W:0]   count_q, count_d;

   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   assign top_idx  = ptr_q - 1'b1;
   assign pop_data = mem_q[top_idx];

   // Pointer wraps naturally, so a push when full lands on the oldest slot.
   always_comb begin
      ptr_d   = ptr_q;
      count_d = count_q;
      if (push) begin
         ptr_d = ptr_q + 1'b1;
         if (!full) count_d = count_q + 1'b1;
      end else if (pop && !empty) begin
         ptr_d   = top_idx;
         count_d = count_q - 1'b1;
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q   <= '0;
         count_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         count_q <= count_d;
      end
   end

   // Entry storage; cleared on reset so no stale return address survives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, fetches over imem req/ack,
// decodes control-flow opcodes and issues to decode over valid/ready.
// Optional return-address stack for CALL/RET is enabled with RAS_EN.
//
//   state | meaning
//   IDLE  | post-reset, one cycle, no request
//   FETCH | imem_req high, waiting for imem_ack
//   ISSUE | instr_valid high, waiting for instr_ready
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int RAS_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  pc_next,
   output logic [7:0]  pc,
   output logic        jump,
   output logic [7:0]  jump_address,
   output logic        branch,
   output logic [7:0]  branch_offset,
   output logic        imem_req,
   output logic [7:0]  imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_rdata,
   input  logic        zero_flag,
   output logic        instr_valid,
   output logic [15:0] instr,
   input  logic        instr_ready,
   output logic        ras_err
);
   state_e      state_q, state_d;
   logic [7:0]  pc_q, pc_d;
   logic [15:0] instr_q, instr_d;
   logic        jump_q, jump_d, branch_q, branch_d;
   logic [7:0]  jump_addr_q, jump_addr_d, branch_off_q, branch_off_d;

   logic [3:0]  opcode;
   logic [7:0]  imm;
   logic        fetch_ack;
   logic        dec_jump, dec_branch;
   logic [7:0]  dec_addr;
   logic        unused_bits;

   assign opcode    = imem_rdata[OPC_MSB:OPC_LSB];
   assign imm       = imem_rdata[IMM_MSB:IMM_LSB];
   assign fetch_ack = (state_q == FETCH) && imem_ack;

`ifdef RAS_EN
   logic       ras_push, ras_pop, ras_full, ras_empty, ras_err_q, ras_err_d;
   logic [7:0] ras_top, ret_addr;

   assign ras_push    = fetch_ack && (opcode == OP_CALL);
   assign ras_pop     = fetch_ack && (opcode == OP_RET);
   assign ret_addr    = pc_q + 8'd1;
   assign unused_bits = ^{imem_rdata[11:8]};

   ras_stack #(.DEPTH(RAS_DEPTH), .W(8)) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (ret_addr),
      .pop_data  (ras_top),
      .full      (ras_full),
      .empty     (ras_empty)
   );

   // Sticky overflow/underflow flag, cleared only by reset.
   always_comb begin
      ras_err_d = ras_err_q | (ras_push && ras_full) | (ras_pop && ras_empty);
   end

   // Error flag register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ras_err_q <= 1'b0;
      else     ras_err_q <= ras_err_d;
   end

   assign ras_err = ras_err_q;
`else
   assign unused_bits = ^{imem_rdata[11:8], RAS_DEPTH[0]};
   assign ras_err     = 1'b0;
`endif

   // Control-flow decode of the word arriving from instruction memory.
   always_comb begin
      dec_jump   = 1'b0;
      dec_branch = 1'b0;
      dec_addr   = imm;
      case (opcode)
         OP_JMP:  dec_jump   = 1'b1;
         OP_BEQZ: dec_branch = zero_flag;
         OP_CALL: dec_jump   = 1'b1;
         OP_RET: begin
`ifdef RAS_EN
            dec_jump = !ras_empty;
            dec_addr = ras_top;
`endif
         end
         default: ;
      endcase
   end

   // Next-state and datapath updates; jump takes priority over branch.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      jump_d       = jump_q;
      jump_addr_d  = jump_addr_q;
      branch_d     = branch_q;
      branch_off_d = branch_off_q;
      case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            if (imem_ack) begin
               state_d  = ISSUE;
               instr_d  = imem_rdata;
               jump_d   = dec_jump;
               branch_d = dec_branch && !dec_jump;
               if (dec_jump) jump_addr_d = dec_addr;
               if (dec_branch && !dec_jump) branch_off_d = imm;
            end
         end
         ISSUE: begin
            if (instr_ready) begin
               state_d  = FETCH;
               pc_d     = pc_next;
               jump_d   = 1'b0;
               branch_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         pc_q         <= 8'd0;
         instr_q      <= 16'h0000;
         jump_q       <= 1'b0;
         jump_addr_q  <= 8'd0;
         branch_q     <= 1'b0;
         branch_off_q <= 8'd0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         jump_q       <= jump_d;
         jump_addr_q  <= jump_addr_d;
         branch_q     <= branch_d;
         branch_off_q <= branch_off_d;
      end
   end

   assign pc            = pc_q;
   assign imem_addr     = pc_q;
   assign jump          = jump_q;
   assign jump_address  = jump_addr_q;
   assign branch        = branch_q;
   assign branch_offset = branch_off_q;
   assign instr         = instr_q;
   assign imem_req      = (state_q == FETCH);
   assign instr_valid   = (state_q == ISSUE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural model of the PC, decode and
// return-address stack, driven with randomized memory/decode timing.
module tb_fetch_sequencer;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, imem_ack, zero_flag, instr_ready;
   logic [15:0] imem_rdata;
   logic [7:0]  pc_next, pc, jump_address, branch_offset, imem_addr;
   logic        jump, branch, imem_req, instr_valid, ras_err;
   logic [15:0] instr;

   int checks = 0;
   int errors = 0;

   logic [7:0]  m_pc;
   logic        m_err;
   logic [7:0]  m_stack[$];
   logic [15:0] exp_instr;
   logic        exp_jump, exp_branch;
   logic [7:0]  exp_ja, exp_bo, exp_next;

   always #5 clk = ~clk;

   // Next-PC logic the sequencer drives.
   assign pc_next = jump ? jump_address : (branch ? pc + branch_offset : pc + 8'd1);

   fetch_sequencer #(.RAS_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .pc_next(pc_next), .pc(pc), .jump(jump),
      .jump_address(jump_address), .branch(branch), .branch_offset(branch_offset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .zero_flag(zero_flag), .instr_valid(instr_valid),
      .instr(instr), .instr_ready(instr_ready), .ras_err(ras_err)
   );

   task automatic apply_reset();
      rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0; zero_flag = 1'b0; imem_rdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_pc = 8'd0; m_err = 1'b0; m_stack.delete();
   endtask

   task automatic model_decode(input logic [15:0] w, input logic zf);
      logic [7:0] imm;
      imm = w[7:0];
      exp_instr = w; exp_jump = 1'b0; exp_branch = 1'b0;
      exp_ja = 8'h00; exp_bo = 8'h00; exp_next = m_pc + 8'd1;
      case (w[15:12])
         4'hC: begin exp_jump = 1'b1; exp_ja = imm; exp_next = imm; end
         4'hD: if (zf) begin exp_branch = 1'b1; exp_bo = imm; exp_next = m_pc + imm; end
         4'hE: begin
`ifdef RAS_EN
            if (m_stack.size() == DEPTH) begin void'(m_stack.pop_front()); m_err = 1'b1; end
            m_stack.push_back(m_pc + 8'd1);
`endif
            exp_jump = 1'b1; exp_ja = imm; exp_next = imm;
         end
         4'hF: begin
`ifdef RAS_EN
            if (m_stack.size() == 0) m_err = 1'b1;
            else begin exp_ja = m_stack.pop_back(); exp_jump = 1'b1; exp_next = exp_ja; end
`endif
         end
         default: ;
      endcase
   endtask

   function automatic logic [15:0] rand_nop();
      logic [3:0] op;
      op = 4'($urandom_range(0, 11));
      return {op, 12'($urandom)};
   endfunction

   task automatic fetch_instr(input logic [15:0] w, input logic zf, input int ack_wait);
      int n = 0;
      while (imem_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc || pc !== m_pc || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL fetch_start req=%b addr=%h pc=%h valid=%b expected req=1 addr=pc=%h valid=0",
                  imem_req, imem_addr, pc, instr_valid, m_pc);
      end
      for (int i = 0; i < ack_wait; i++) begin
         instr_ready = 1'($urandom_range(0, 1));
         imem_rdata  = 16'($urandom);
         @(negedge clk);
         checks++;
         if (imem_req !== 1'b1 || pc !== m_pc || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait req=%b pc=%h valid=%b expected req=1 pc=%h valid=0",
                     imem_req, pc, instr_valid, m_pc);
         end
      end
      instr_ready = 1'b0; imem_ack = 1'b1; imem_rdata = w; zero_flag = zf;
      model_decode(w, zf);
      @(negedge clk);
      imem_ack = 1'b0; imem_rdata = 16'($urandom); zero_flag = 1'($urandom_range(0, 1));
   endtask

   task automatic issue_instr(input int ready_wait);
      for (int i = 0; i <= ready_wait; i++) begin
         checks++;
         if ({instr_valid, instr, jump, branch, imem_req, pc, ras_err,
              jump ? jump_address : 8'h00, branch ? branch_offset : 8'h00} !==
             {1'b1, exp_instr, exp_jump, exp_branch, 1'b0, m_pc, m_err, exp_ja, exp_bo}) begin
            errors++;
            $display("FAIL issue_hold cyc=%0d got valid=%b instr=%h j=%b ja=%h b=%b bo=%h req=%b pc=%h err=%b expected valid=1 instr=%h j=%b ja=%h b=%b bo=%h req=0 pc=%h err=%b",
                     i, instr_valid, instr, jump, jump_address, branch, branch_offset, imem_req, pc, ras_err,
                     exp_instr, exp_jump, exp_ja, exp_branch, exp_bo, m_pc, m_err);
         end
         if (i < ready_wait) begin
            imem_ack = 1'($urandom_range(0, 1)); imem_rdata = 16'($urandom);
            zero_flag = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
      end
      imem_ack = 1'b0; instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      m_pc = exp_next;
      checks++;
      if ({pc, jump, branch, instr_valid, imem_req} !== {m_pc, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL issue_done pc=%h j=%b b=%b valid=%b req=%b expected pc=%h j=0 b=0 valid=0 req=1",
                  pc, jump, branch, instr_valid, imem_req, m_pc);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; imem_ack = 1'b1; instr_ready = 1'b1; imem_rdata = 16'hC0FF; zero_flag = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({pc, jump, jump_address, branch, branch_offset, imem_req, imem_addr, instr_valid, instr, ras_err} !== '0) begin
         errors++;
         $display("FAIL reset_values pc=%h j=%b ja=%h b=%b bo=%h req=%b addr=%h valid=%b instr=%h err=%b expected all zero",
                  pc, jump, jump_address, branch, branch_offset, imem_req, imem_addr, instr_valid, instr, ras_err);
      end
      imem_ack = 1'b0; instr_ready = 1'b0;
      rst = 1'b0; m_pc = 8'd0; m_err = 1'b0; m_stack.delete();
      #1;
      checks++;
      if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_idle req=%b expected 0", imem_req); end
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'd0) begin
         errors++; $display("FAIL reset_first_fetch req=%b addr=%h expected req=1 addr=00", imem_req, imem_addr);
      end
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 3; i++) begin
         fetch_instr(rand_nop(), 1'($urandom_range(0, 1)), 1);
         issue_instr(0);
      end
      checks++;
      if (pc !== 8'd3 || imem_addr !== 8'd3) begin
         errors++; $display("FAIL seq_pc pc=%h addr=%h expected 03", pc, imem_addr);
      end
   endtask

   task automatic test_jmp();
      repeat (2) begin fetch_instr(rand_nop(), 1'b0, 0); issue_instr(0); end
      fetch_instr(16'hC042, 1'b0, 0);
      checks++;
      if (pc !== 8'd5 || jump !== 1'b1 || jump_address !== 8'h42) begin
         errors++; $display("FAIL jmp_issue pc=%h j=%b ja=%h expected pc=05 j=1 ja=42", pc, jump, jump_address);
      end
      issue_instr(2);
      checks++;
      if (pc !== 8'h42) begin errors++; $display("FAIL jmp_target pc=%h expected 42", pc); end
   endtask

   task automatic test_beqz();
      fetch_instr(16'hC00A, 1'b0, 0); issue_instr(0);
      fetch_instr(16'hD0FE, 1'b1, 1);
      checks++;
      if (branch !== 1'b1 || branch_offset !== 8'hFE || jump !== 1'b0) begin
         errors++; $display("FAIL beqz_taken b=%b bo=%h j=%b expected b=1 bo=fe j=0", branch, branch_offset, jump);
      end
      issue_instr(1);
      checks++;
      if (pc !== 8'd8) begin errors++; $display("FAIL beqz_taken_pc pc=%h expected 08", pc); end
      fetch_instr(16'hC00A, 1'b0, 0); issue_instr(0);
      fetch_instr(16'hD0FE, 1'b0, 0);
      issue_instr(0);
      checks++;
      if (pc !== 8'd11) begin errors++; $display("FAIL beqz_not_taken_pc pc=%h expected 0b", pc); end
   endtask

   task automatic test_backpressure();
      fetch_instr({4'hC, 4'h0, 8'($urandom)}, 1'b0, 0);
      issue_instr(5);
      fetch_instr({4'hD, 4'h0, 8'($urandom)}, 1'b1, 2);
      issue_instr(5);
   endtask

   task automatic test_ras();
      apply_reset();
      fetch_instr(16'hC010, 1'b0, 0); issue_instr(0);
      fetch_instr(16'hE020, 1'b0, 0); issue_instr(0);
      fetch_instr(16'hF000, 1'b0, 0);
      checks++;
`ifdef RAS_EN
      if (jump !== 1'b1 || jump_address !== 8'h11 || ras_err !== 1'b0) begin
         errors++; $display("FAIL ras_ret j=%b ja=%h err=%b expected j=1 ja=11 err=0", jump, jump_address, ras_err);
      end
`else
      if (jump !== 1'b0 || ras_err !== 1'b0) begin
         errors++; $display("FAIL ret_plain j=%b err=%b expected j=0 err=0", jump, ras_err);
      end
`endif
      issue_instr(0);
      for (int i = 0; i < 5; i++) begin
         fetch_instr({4'hE, 4'h0, 8'($urandom)}, 1'b0, 0); issue_instr(0);
      end
      checks++;
`ifdef RAS_EN
      if (ras_err !== 1'b1) begin errors++; $display("FAIL ras_overflow err=%b expected 1", ras_err); end
`else
      if (ras_err !== 1'b0) begin errors++; $display("FAIL ras_tied err=%b expected 0", ras_err); end
`endif
      apply_reset();
      fetch_instr(16'hF000, 1'b0, 0); issue_instr(0);
      checks++;
`ifdef RAS_EN
      if (pc !== 8'd1 || ras_err !== 1'b1) begin
         errors++; $display("FAIL ras_underflow pc=%h err=%b expected pc=01 err=1", pc, ras_err);
      end
`else
      if (pc !== 8'd1 || ras_err !== 1'b0) begin
         errors++; $display("FAIL ret_empty pc=%h err=%b expected pc=01 err=0", pc, ras_err);
      end
`endif
   endtask

   task automatic test_random();
      logic [15:0] w;
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 5))
            0:       w = {4'hC, 12'($urandom)};
            1:       w = {4'hD, 12'($urandom)};
            2:       w = {4'hE, 12'($urandom)};
            3:       w = {4'hF, 12'($urandom)};
            default: w = rand_nop();
         endcase
         fetch_instr(w, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
         issue_instr($urandom_range(0, 3));
      end
   endtask

   task automatic test_async_reset();
      fetch_instr(16'hE077, 1'b0, 0);
      checks++;
      if (instr_valid !== 1'b1 || jump !== 1'b1) begin
         errors++; $display("FAIL areset_setup valid=%b j=%b expected 1 1", instr_valid, jump);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({pc, jump, branch, instr_valid, imem_req, ras_err, instr} !== '0) begin
         errors++;
         $display("FAIL areset_clear pc=%h j=%b b=%b valid=%b req=%b err=%b instr=%h expected all zero",
                  pc, jump, branch, instr_valid, imem_req, ras_err, instr);
      end
      @(negedge clk);
      rst = 1'b0; m_pc = 8'd0; m_err = 1'b0; m_stack.delete();
      fetch_instr(16'hF000, 1'b0, 0); issue_instr(0);
      fetch_instr(rand_nop(), 1'b0, 1); issue_instr(1);
   endtask

   initial begin
      rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0; zero_flag = 1'b0; imem_rdata = '0;
      m_pc = 8'd0; m_err = 1'b0;
      test_reset();
      test_sequential();
      test_jmp();
      test_beqz();
      test_backpressure();
      test_ras();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
